max6675_sampler: RTL

MAX6675_SAMPLER -- requirements
Module: max6675_sampler

---
 rtl/max6675_sampler.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/max6675_sampler.sv
// max6675_sampler: periodic MAX6675 conversion scheduler with timeout, moving average and alarm.
// Define MAX6675_ALARM_EN to build the over-temperature alarm; otherwise alarm_high is tied low.
module max6675_sampler #(
    parameter int unsigned PERIOD_CYCLES  = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned AVG_LOG2       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        dec_finish,
    input  logic        dec_idle,
    input  logic [15:0] dec_data,
    input  logic [11:0] setpoint_hi,
    input  logic [7:0]  hyst,
    output logic        dec_start,
    output logic [11:0] temp_raw,
    output logic [11:0] temp_avg,
    output logic        temp_valid,
    output logic        tc_open,
    output logic        timeout_err,
    output logic        alarm_high
);

    localparam int unsigned TEMP_W   = 12;
    localparam int unsigned DEPTH    = 1 << AVG_LOG2;
    localparam int unsigned SUM_W    = TEMP_W + AVG_LOG2;
    localparam int unsigned PTR_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned TO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned PER_W    = (PERIOD_CYCLES > 0) ? $clog2(PERIOD_CYCLES + 1) : 1;
    localparam int unsigned PER_LAST = (PERIOD_CYCLES > 0) ? PERIOD_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_FINISH,
        CAPTURE,
        UPDATE,
        WAIT_PERIOD
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                timeout_hit_c;
    logic                per_done_c;
    logic                good_sample_c;
    logic [TEMP_W-1:0]   sample_c;
    logic [TO_W-1:0]     to_cnt_q;
    logic [PER_W-1:0]    per_cnt_q;
    logic [SUM_W-1:0]    sum_q;
    logic                filled_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_next_c;
    logic [TEMP_W-1:0]   avg_buf [DEPTH];

    assign sample_c      = dec_data[14:3];
    assign good_sample_c = (state_q == CAPTURE) && !dec_data[2];
    assign per_done_c    = (per_cnt_q >= PER_W'(PER_LAST));
    assign wr_ptr_next_c = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);

    // Bits outside the temperature field and the open flag carry nothing we use
    logic unused_dec_bits;
    assign unused_dec_bits = ^{dec_data[15], dec_data[1:0]};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a finish pulse on the expiry cycle wins over the timeout
    always_comb begin
        state_d       = state_q;
        timeout_hit_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && dec_idle) begin
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (!dec_idle) begin
                    state_d = WAIT_FINISH;
                end
            end
            WAIT_FINISH: begin
                if (dec_finish) begin
                    state_d = CAPTURE;
                end else if (to_cnt_q <= TO_W'(1)) begin
                    state_d       = WAIT_PERIOD;
                    timeout_hit_c = 1'b1;
                end
            end
            CAPTURE: begin
                state_d = dec_data[2] ? WAIT_PERIOD : UPDATE;
            end
            UPDATE: begin
                state_d = WAIT_PERIOD;
            end
            WAIT_PERIOD: begin
                if (!enable || per_done_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request strobe follows the registered state so it falls with reset at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_start <= 1'b0;
        end else begin
            dec_start <= (state_d == REQUEST);
        end
    end

    // Timeout and period counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q  <= '0;
            per_cnt_q <= '0;
        end else begin
            if (state_q == REQUEST) begin
                to_cnt_q <= TO_W'(TIMEOUT_CYCLES);
            end else if ((state_q == WAIT_FINISH) && (to_cnt_q != '0)) begin
                to_cnt_q <= to_cnt_q - TO_W'(1);
            end

            if (state_q == WAIT_PERIOD) begin
                per_cnt_q <= per_cnt_q + PER_W'(1);
            end else begin
                per_cnt_q <= '0;
            end
        end
    end

    // Sample capture, running sum and averaged output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            temp_raw    <= '0;
            temp_avg    <= '0;
            temp_valid  <= 1'b0;
            tc_open     <= 1'b0;
            timeout_err <= 1'b0;
            sum_q       <= '0;
            filled_q    <= 1'b0;
            wr_ptr_q    <= '0;
        end else begin
            temp_valid <= 1'b0;

            if (timeout_hit_c) begin
                timeout_err <= 1'b1;
            end

            if (state_q == CAPTURE) begin
                tc_open <= dec_data[2];
            end

            if (good_sample_c) begin
                temp_raw    <= sample_c;
                timeout_err <= 1'b0;
                filled_q    <= 1'b1;
                wr_ptr_q    <= wr_ptr_next_c;
                if (filled_q) begin
                    sum_q <= sum_q + SUM_W'(sample_c) - SUM_W'(avg_buf[wr_ptr_q]);
                end else begin
                    sum_q <= SUM_W'(sample_c) << AVG_LOG2;
                end
            end

            if (state_q == UPDATE) begin
                temp_avg   <= TEMP_W'(sum_q >> AVG_LOG2);
                temp_valid <= 1'b1;
            end
        end
    end

    // Averaging window; the first sample after reset seeds every entry
    always_ff @(posedge clk) begin
        if (good_sample_c) begin
            if (!filled_q) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    avg_buf[i] <= sample_c;
                end
            end else begin
                avg_buf[wr_ptr_q] <= sample_c;
            end
        end
    end

`ifdef MAX6675_ALARM_EN
    logic [TEMP_W-1:0] clr_thr_c;

    // Clear threshold saturates at zero when hysteresis exceeds the setpoint
    assign clr_thr_c = (setpoint_hi >= TEMP_W'(hyst)) ? setpoint_hi - TEMP_W'(hyst) : '0;

    // Evaluated on the edge after temp_avg updates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_high <= 1'b0;
        end else if (temp_valid) begin
            if (temp_avg >= setpoint_hi) begin
                alarm_high <= 1'b1;
            end else if (temp_avg < clr_thr_c) begin
                alarm_high <= 1'b0;
            end
        end
    end
`else
    logic unused_alarm_cfg;
    assign unused_alarm_cfg = ^{setpoint_hi, hyst};
    assign alarm_high       = 1'b0;
`endif

endmodule
